// File: rtl/cdr_phase_ctrl.sv
// Digital CDR phase loop: Alexander bang-bang PD, majority-vote decimator, PI loop filter, circular PI code.
// Optional lock detector enabled by defining CDR_LOCK_DET_EN (adds the cdr_lock output).
module cdr_phase_ctrl #(
   parameter int CODE_W    = 11,
   parameter int CODE_INIT = 0,
   parameter int VOTE_LEN  = 8,
   parameter int KP        = 4,
   parameter int INT_W     = 16,
   parameter int INT_SHIFT = 6,
   parameter int ACQ_WIN   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cdr_en,
   input  logic              freeze,
   input  logic              smp_vld,
   input  logic              data_smp,
   input  logic              edge_smp,
   output logic [CODE_W-1:0] pi_code,
   output logic              code_upd,
   output logic [1:0]        loop_state,
   output logic [INT_W-1:0]  int_acc
`ifdef CDR_LOCK_DET_EN
   ,
   output logic              cdr_lock
`endif
);

   localparam int CNT_W = $clog2(VOTE_LEN);
   localparam int NET_W = CNT_W + 2;
   localparam int ACQ_W = $clog2(ACQ_WIN + 1);
   localparam logic signed [31:0] INT_MAX = (32'sd1 <<< (INT_W - 1)) - 32'sd1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACQ   = 2'b01,
      TRACK = 2'b10,
      HOLD  = 2'b11
   } state_t;

   state_t                  state, state_nxt, ret_state;
   logic                    d_prev;
   logic [CNT_W-1:0]        smp_cnt;
   logic signed [NET_W-1:0] net, net_sum, win_net;
   logic                    win_close;
   logic [ACQ_W-1:0]        acq_cnt;
   logic                    trans, early, late, running, stop, counting, close, apply;
   logic                    dir_pos, dir_neg;
   logic signed [31:0]      int_ext, int_new, kp_eff, delta_p, delta;
   logic [CODE_W-1:0]       code_nxt;

   function automatic logic signed [31:0] sat_int(input logic signed [31:0] v);
      if (v > INT_MAX)       sat_int = INT_MAX;
      else if (v < -INT_MAX) sat_int = -INT_MAX;
      else                   sat_int = v;
   endfunction

   // Phase detector, vote accumulation and loop-filter datapath
   always_comb begin
      trans    = d_prev ^ data_smp;
      early    = smp_vld && trans && (edge_smp == d_prev);
      late     = smp_vld && trans && (edge_smp == data_smp);
      running  = (state == ACQ) || (state == TRACK);
      stop     = !cdr_en || freeze;
      counting = running && !stop && smp_vld;
      close    = counting && (smp_cnt == CNT_W'(VOTE_LEN - 1));
      apply    = win_close && running && !stop;
      if (early)     net_sum = net + NET_W'(1);
      else if (late) net_sum = net - NET_W'(1);
      else           net_sum = net;
      dir_neg = win_net[NET_W-1];
      dir_pos = !win_net[NET_W-1] && (win_net != '0);
      int_ext = {{(32 - INT_W){int_acc[INT_W-1]}}, int_acc};
      kp_eff  = (state == ACQ) ? 32'(2 * KP) : 32'(KP);
      // The integrator only moves in TRACK; in ACQ its frozen value still steers the code
      if (state == TRACK) begin
         if (dir_pos)      int_new = sat_int(int_ext + 32'sd1);
         else if (dir_neg) int_new = sat_int(int_ext - 32'sd1);
         else              int_new = int_ext;
      end else begin
         int_new = int_ext;
      end
      if (dir_pos)      delta_p = kp_eff;
      else if (dir_neg) delta_p = -kp_eff;
      else              delta_p = 32'sd0;
      delta    = delta_p + (int_new >>> INT_SHIFT);
      code_nxt = pi_code + delta[CODE_W-1:0];
   end

   // Loop state next-state logic; disable outranks freeze
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cdr_en) state_nxt = ACQ;
            else        state_nxt = IDLE;
         end
         ACQ: begin
            if (!cdr_en)      state_nxt = IDLE;
            else if (freeze)  state_nxt = HOLD;
            else if (apply && (acq_cnt == ACQ_W'(ACQ_WIN - 1))) state_nxt = TRACK;
            else              state_nxt = ACQ;
         end
         TRACK: begin
            if (!cdr_en)     state_nxt = IDLE;
            else if (freeze) state_nxt = HOLD;
            else             state_nxt = TRACK;
         end
         HOLD: begin
            if (!cdr_en)      state_nxt = IDLE;
            else if (!freeze) state_nxt = ret_state;
            else              state_nxt = HOLD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, vote window and loop filter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ret_state <= ACQ;
         d_prev    <= 1'b0;
         smp_cnt   <= '0;
         net       <= '0;
         win_net   <= '0;
         win_close <= 1'b0;
         acq_cnt   <= '0;
         pi_code   <= CODE_W'(CODE_INIT);
         code_upd  <= 1'b0;
         int_acc   <= '0;
      end else begin
         state    <= state_nxt;
         code_upd <= 1'b0;
         if (smp_vld) d_prev <= data_smp;
         if (running && freeze) ret_state <= state;
         if (!running || stop) begin
            smp_cnt   <= '0;
            net       <= '0;
            win_close <= 1'b0;
         end else if (close) begin
            smp_cnt   <= '0;
            net       <= '0;
            win_net   <= net_sum;
            win_close <= 1'b1;
         end else if (counting) begin
            smp_cnt   <= smp_cnt + CNT_W'(1);
            net       <= net_sum;
            win_close <= 1'b0;
         end else begin
            win_close <= 1'b0;
         end
         if (!cdr_en) begin
            int_acc <= '0;
            acq_cnt <= '0;
         end else if (apply) begin
            pi_code  <= code_nxt;
            code_upd <= (code_nxt != pi_code);
            if (state == TRACK) int_acc <= int_new[INT_W-1:0];
            if (state == ACQ)   acq_cnt <= acq_cnt + ACQ_W'(1);
         end
      end
   end

   assign loop_state = state;

`ifdef CDR_LOCK_DET_EN
   logic [4:0]       lock_cnt;
   logic [NET_W-1:0] abs_net;

   assign abs_net = win_net[NET_W-1] ? NET_W'(-win_net) : NET_W'(win_net);

   // Lock after 16 consecutive quiet TRACK windows, drop on a noisy window or loop interruption
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_cnt <= 5'd0;
         cdr_lock <= 1'b0;
      end else if (!cdr_en || ((state == HOLD) && !freeze)) begin
         lock_cnt <= 5'd0;
         cdr_lock <= 1'b0;
      end else if (apply && (state == TRACK)) begin
         if (abs_net > NET_W'(VOTE_LEN / 2)) begin
            lock_cnt <= 5'd0;
            cdr_lock <= 1'b0;
         end else if (abs_net <= NET_W'(VOTE_LEN / 4)) begin
            if (lock_cnt != 5'd16) lock_cnt <= lock_cnt + 5'd1;
            if (lock_cnt >= 5'd15) cdr_lock <= 1'b1;
         end else begin
            lock_cnt <= 5'd0;
         end
      end
   end
`endif

endmodule
